// File: rtl/transmitter.sv
// rtl/transmitter.sv - serial frame transmitter: start, LSB-first payload, even parity, stop
// One-entry holding register lets the next byte queue behind the current frame.
module transmitter #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_bit,
    output logic                  busy,
    output logic                  done
);
    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic [DATA_WIDTH-1:0]   hold_q, hold_d;
    logic                    hold_valid_q, hold_valid_d;
    logic [CW-1:0]           bit_cnt_q, bit_cnt_d;
    logic                    out_bit_q, out_bit_d;
    logic                    hs;
    logic                    load_point;

    assign in_ready = !hold_valid_q && !arst;
    assign hs       = in_valid && in_ready;
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_STOP);
    assign out_bit  = out_bit_q;

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        bit_cnt_d    = bit_cnt_q;
        load_point   = 1'b0;

        case (state_q)
            S_IDLE, S_STOP: load_point = 1'b1;
            S_START: begin
                state_d   = S_DATA;
                bit_cnt_d = '0;
            end
            S_DATA: begin
                if (bit_cnt_q == LAST_BIT) begin
                    state_d = S_PARITY;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            S_PARITY: state_d = S_STOP;
            default:  state_d = S_IDLE;
        endcase

        // The held byte wins at a load point; in_ready is low then, so no handshake can collide.
        if (load_point) begin
            if (hold_valid_q) begin
                shift_d      = hold_q;
                hold_valid_d = 1'b0;
                state_d      = S_START;
            end else if (hs) begin
                shift_d = in_data;
                state_d = S_START;
            end else begin
                state_d = S_IDLE;
            end
        end else if (hs) begin
            hold_d       = in_data;
            hold_valid_d = 1'b1;
        end

        case (state_d)
            S_START:  out_bit_d = 1'b1;
            S_DATA:   out_bit_d = shift_d[bit_cnt_d];
            S_PARITY: out_bit_d = ^shift_d;
            S_STOP:   out_bit_d = 1'b1;
            default:  out_bit_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q      <= S_IDLE;
            shift_q      <= '0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            bit_cnt_q    <= '0;
            out_bit_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            bit_cnt_q    <= bit_cnt_d;
            out_bit_q    <= out_bit_d;
        end
    end
endmodule

// File: doc/transmitter.md
TRANSMITTER -- requirements
Module: transmitter

Interface
REQ-001 Parameter: DATA_WIDTH, default 8, payload bits per frame.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 arst  input  1  asynchronous reset, active-high.
REQ-004 in_valid  input  1  in_data holds a byte to send.
REQ-005 in_ready  output  1  block can accept a byte this cycle.
REQ-006 in_data  input  DATA_WIDTH  payload, sampled on handshake.
REQ-007 out_bit  output  1  registered serial line; idle level 0.
REQ-008 busy  output  1  frame in progress.
REQ-009 done  output  1  high during the stop-bit cycle of each frame.

Function
REQ-010 Handshake: a byte transfers at a rising edge where in_valid=1 and in_ready=1; no transfer otherwise.
REQ-011 A one-entry holding register (hold, hold_valid) buffers a byte accepted while a frame is in progress.
REQ-012 in_ready = !hold_valid, forced 0 while arst=1.
REQ-013 States: IDLE, START, DATA, PARITY, STOP; out_bit is the registered value for the current state.
REQ-014 out_bit per state: IDLE 0; START 1; DATA shift[bit_cnt], LSB first; PARITY XOR of all DATA_WIDTH payload bits; STOP 1.
REQ-015 START, PARITY and STOP each last exactly 1 cycle; DATA lasts exactly DATA_WIDTH cycles, bit_cnt 0..DATA_WIDTH-1; frame = DATA_WIDTH+3 cycles.
REQ-016 Frame-load points: the edge leaving IDLE and the edge leaving STOP.
REQ-017 At a frame-load point: if hold_valid=1, load shift from hold, clear hold_valid, go to START; else if a handshake occurs on that edge, load shift from in_data, go to START; else go to IDLE.
REQ-018 A handshake at any other edge writes in_data into hold and sets hold_valid.
REQ-019 Latency: a byte accepted at edge E while IDLE drives START on out_bit in the cycle after E.
REQ-020 Back-to-back: a byte pending at the end of STOP starts with zero idle cycles between frames.
REQ-021 Parity is computed on the byte captured at load; later in_data changes have no effect.
REQ-022 busy = (state != IDLE); done = (state == STOP); both combinational from state.
REQ-023 bit_cnt width is clog2(DATA_WIDTH) or more; it resets to 0 on entering DATA.

Reset
REQ-024 While arst=1: state=IDLE, out_bit=0, busy=0, done=0, in_ready=0, hold_valid=0, shift=0, bit_cnt=0.
REQ-025 Reset mid-frame aborts immediately; the partial frame and the held byte are discarded.
REQ-026 After arst falls, in_ready=1 from the first cycle, and the first handshake obeys REQ-019.

Verification
REQ-027 Idle, send 8'hA5 -> out_bit over 11 cycles = 1,1,0,1,0,0,1,0,1,0,1; done high on cycle 11 only; busy high for 11 cycles.
REQ-028 Send 8'h01 -> out_bit = 1,1,0,0,0,0,0,0,0,1,1; parity bit 1.
REQ-029 Send 8'h3C, then 8'hC3 accepted during the first frame -> 22 consecutive busy cycles, second START immediately after first STOP, in_ready low from the second handshake until the second frame loads.
REQ-030 With a frame in progress and hold full, hold in_valid=1 -> in_ready=0, no third byte accepted; in_ready rises on the cycle after the STOP->START edge.
REQ-031 Assert arst during DATA bit 4 of 8'hFF with a held byte pending -> out_bit=0, busy=0 at once; after release, line stays 0 and no frame is sent until a new handshake.
REQ-032 Loopback against the team receiver, 256 random bytes back-to-back -> every byte reproduced in order with correct parity.
